fifo_sync_flags: RTL and testbench

Parametrised synchronous FIFO with occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It correctly handles a simultaneous read and write in the same cycle, including when the FIFO is full. It buffers data between a producer and a consumer on a single clock domain in the lab datapath. It supersedes the fixed-function FIFO for all new producer/consumer links.

---
 rtl/fifo_sync_flags.sv | 115 +++++++++++
 tb/tb_fifo_sync_flags.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise the read data is registered.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             rd_acc, wr_acc;

  // Flags decode the registered count only, so wr_en/rd_en never reach them combinationally.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is legal only when a read frees the head slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error in the clearing cycle wins over clr_err.
    ovf_d = (ovf_q & ~clr_err) | (wr_en & ~wr_acc);
    unf_d = (unf_q & ~clr_err) | (rd_en & ~rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is never reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

`ifdef FIFO_FWFT_EN
  assign dout       = empty ? '0 : mem[rd_ptr_q];
  assign dout_valid = ~empty;
`else
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  // On a full read+write the old head is captured here before the write lands in that slot.
  always_comb begin
    dout_d       = rd_acc ? mem[rd_ptr_q] : dout_q;
    dout_valid_d = rd_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`endif

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed table-driven bench for fifo_sync_flags with WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.
module tb_fifo_sync_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       ovf;
    logic       unf;
    logic       dv;
    logic [7:0] dout;
  } vec_t;

  vec_t vq[$];

  fifo_sync_flags #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [7:0] d, input logic r, input logic c,
                     input int cnt, input logic ovf, input logic unf, input logic dv,
                     input logic [7:0] dq);
    vec_t v;
    v.wr = w; v.din = d; v.rd = r; v.clr = c; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.dv = dv; v.dout = dq;
    vq.push_back(v);
  endtask

  task automatic chk_state(input string nm, input int cnt);
    chk({nm, " count"}, 32'(count), 32'(cnt));
    chk({nm, " full"}, 32'(full), 32'(cnt == DEPTH));
    chk({nm, " empty"}, 32'(empty), 32'(cnt == 0));
    chk({nm, " almost_full"}, 32'(almost_full), 32'(cnt >= AF));
    chk({nm, " almost_empty"}, 32'(almost_empty), 32'(cnt <= AE));
  endtask

  initial begin
    // Fill, overflow, drain
    add(1, 8'h11, 0, 0, 1, 0, 0, 0, 8'h00);
    add(1, 8'h22, 0, 0, 2, 0, 0, 0, 8'h00);
    add(1, 8'h33, 0, 0, 3, 0, 0, 0, 8'h00);
    add(1, 8'h44, 0, 0, 4, 0, 0, 0, 8'h00);
    add(1, 8'h55, 0, 0, 4, 1, 0, 0, 8'h00);
    add(0, 8'h00, 1, 0, 3, 1, 0, 1, 8'h11);
    add(0, 8'h00, 1, 0, 2, 1, 0, 1, 8'h22);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1, 8'h33);
    add(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h44);
    add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h44);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h44);
    // Refill, then simultaneous read+write while full
    add(1, 8'hA1, 0, 0, 1, 0, 0, 0, 8'h44);
    add(1, 8'hA2, 0, 0, 2, 0, 0, 0, 8'h44);
    add(1, 8'hA3, 0, 0, 3, 0, 0, 0, 8'h44);
    add(1, 8'hA4, 0, 0, 4, 0, 0, 0, 8'h44);
    add(1, 8'h66, 1, 0, 4, 0, 0, 1, 8'hA1);
    add(0, 8'h00, 1, 0, 3, 0, 0, 1, 8'hA2);
    add(0, 8'h00, 1, 0, 2, 0, 0, 1, 8'hA3);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 8'hA4);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h66);
    // Simultaneous read+write while empty, error clear priorities
    add(1, 8'h77, 1, 0, 1, 0, 1, 0, 8'h66);
    add(0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h66);
    add(0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h77);
    add(0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h77);
    add(0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h77);
    // Priming write then 20 cycles of streaming (pointers wrap 5 times)
    add(1, 8'h80, 0, 0, 1, 0, 0, 0, 8'h77);
    for (int i = 0; i < 20; i++)
      add(1, 8'(8'h81 + i), 1, 0, 1, 0, 0, 1, 8'(8'h80 + i));

    // Reset state
    #1;
    chk_state("reset", 0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset underflow", 32'(underflow), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);
    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      wr_en = vq[i].wr; din = vq[i].din; rd_en = vq[i].rd; clr_err = vq[i].clr;
      @(posedge clk); #1;
      chk_state(nm, vq[i].cnt);
      chk({nm, " overflow"}, 32'(overflow), 32'(vq[i].ovf));
      chk({nm, " underflow"}, 32'(underflow), 32'(vq[i].unf));
`ifndef FIFO_FWFT_EN
      chk({nm, " dout_valid"}, 32'(dout_valid), 32'(vq[i].dv));
      chk({nm, " dout"}, 32'(dout), 32'(vq[i].dout));
`endif
    end

    // Asynchronous reset in the middle of streaming
    wr_en = 1'b1; din = 8'h99; rd_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_state("midrst", 0);
    chk("midrst dout", 32'(dout), 32'd0);
    chk("midrst dout_valid", 32'(dout_valid), 32'd0);
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    @(posedge clk); #1;
    chk_state("midrst hold", 0);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef FIFO_FWFT_EN
    // First-word-fall-through: word is shown without a read, popped by rd_en
    wr_en = 1'b1; din = 8'hA5;
    @(posedge clk); #1;
    wr_en = 1'b0; din = '0;
    @(posedge clk); #1;
    chk_state("fwft wr", 1);
    chk("fwft dout", 32'(dout), 32'hA5);
    chk("fwft dout_valid", 32'(dout_valid), 32'd1);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk_state("fwft pop", 0);
    chk("fwft pop dout", 32'(dout), 32'd0);
    chk("fwft pop dout_valid", 32'(dout_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
